tmds_decoder_align: RTL and testbench
=====================================

Name: tmds_decoder_align

Overview:
Receive-side counterpart of the DVI/TMDS encode path. Takes one 10-bit TMDS symbol per pixel clock from an external deserializer and decodes it to 8-bit pixel data, DE and the 2-bit control code. It also runs a word-alignment state machine that pulses a bitslip request to the deserializer until control tokens are reliably detected. One instance is used per colour channel, and the blue instance's control code carries hsync and vsync.

Parameters:
C_window_bits, 12, log2 of the observation window in pixel clocks; 4096 exceeds one 1024x768 line.
C_ctrl_min, 64, number of control tokens required inside one window to declare lock.
C_slip_wait, 16, idle cycles after each bitslip pulse, allowing the deserializer to settle.

Ports:
clk_pixel  in  1  pixel clock; all logic is in this single domain.
rst  in  1  asynchronous, active-high reset.
in_symbol  in  10  TMDS symbol; bit 0 is the first bit on the wire; valid every cycle.
out_data  out  8  decoded pixel data.
out_c  out  2  decoded control code {c1,c0}.
out_de  out  1  1 = data symbol, 0 = control symbol.
out_locked  out  1  word alignment achieved.
out_bitslip  out  1  one-cycle request to shift deserializer alignment by 1 bit.
out_slip_count  out  4  number of slips applied, 0..9.

Behaviour:
- Reset: all outputs are 0 and the FSM is in SEARCH. All counters are 0.
- Reset mid-operation: everything clears asynchronously. Decoding resumes on the first clock edge after rst falls, and the pipeline refills.
- Latency: 2 cycles from in_symbol to out_data/out_c/out_de.
  - Stage 1 registers the symbol.
  - Stage 2 registers the decode.
- Control tokens:
  - 0x354 → c=00
  - 0x0AB → c=01
  - 0x154 → c=10
  - 0x2AB → c=11
  - Each of these forces out_de=0 and out_data=0.
- Data symbols (any other value) set out_de=1.
  - q = in_symbol[9] ? ~in_symbol[7:0] : in_symbol[7:0].
  - d[0] = q[0].
  - For i=1..7: d[i] = in_symbol[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
  - out_c holds its last control value.
- Decoding is independent of lock state. Outputs are always driven; consumers qualify them with out_locked.
- Window counter: C_window_bits wide, free-running, wraps to 0.
- Control counter: counts stage-1 control tokens, saturates at C_ctrl_min, clears at each window wrap.
- FSM states are SEARCH, SLIP, SETTLE and LOCKED.
  - SEARCH:
    - Counter reaches C_ctrl_min → LOCKED; out_locked=1 on the following cycle.
    - Window wraps with count < C_ctrl_min → SLIP.
  - SLIP: out_bitslip=1 for exactly one cycle. out_slip_count increments and wraps from 9 to 0. Next state is SETTLE.
  - SETTLE: wait C_slip_wait cycles. Then restart the window (window and control counters cleared) → SEARCH.
  - LOCKED:
    - A window that wraps with zero control tokens → SEARCH, with out_locked=0 immediately.
    - Any nonzero count keeps lock (hysteresis).
- out_bitslip is never asserted outside SLIP, so consecutive pulses are at least C_slip_wait+1 cycles apart.
- Simultaneous events: if the control count reaches C_ctrl_min in the same cycle the window wraps, reaching the count wins → LOCKED.

Decomposition:
- Shared package tmds_pkg holds:
  - the four control-token constants, also used by the encoder;
  - the FSM state enum;
  - a pure function tmds_decode(sym) → {de, c, data}.
- Natural sub-module: tmds_align_fsm, containing the window counter, control counter, FSM and slip counter. Its input is a per-cycle control-token flag.
- The top level contains the two-stage decode pipeline and instantiates tmds_align_fsm.

Test Plan:
- Feed 0x354, 0x0AB, 0x154, 0x2AB on consecutive cycles → 2 cycles later out_c = 00, 01, 10, 11 with out_de=0 and out_data=0.
- Run all 256 bytes through a reference TMDS encoder with running disparity → out_data equals each byte 2 cycles later with out_de=1 and no mismatches.
- Build a 1344-cycle line stream (1024 data, 320 control 0x354) rotated by 3 bits; deserializer model honours out_bitslip → exactly 7 bitslip pulses spaced ≥17 cycles apart, then out_locked=1 and out_slip_count=7.
- After lock, send 4096 consecutive data-only symbols → out_locked drops at the window wrap and the FSM re-enters SEARCH. Restoring blanking → relock without further slips.
- Assert rst for 1 cycle while LOCKED with slip_count=5 → all outputs 0 asynchronously, and the search restarts from slip_count 0.
- Stream with only 63 control tokens per window → never locks and a bitslip is issued every window. Stream with 64 tokens, the 64th arriving on the window-wrap cycle → locks.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token symbols, alignment FSM states and the
// combinational symbol decoder used by the receive path.
package tmds_pkg;

   localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
   localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
   localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
   localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SLIP   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_LOCKED = 2'd3
   } align_state_t;

   typedef struct packed {
      logic       de;
      logic [1:0] c;
      logic [7:0] data;
   } tmds_dec_t;

   function automatic tmds_dec_t tmds_decode(input logic [9:0] sym);
      tmds_dec_t  r;
      logic [7:0] q;
      r = '0;
      q = sym[9] ? ~sym[7:0] : sym[7:0];
      case (sym)
         TMDS_CTRL_00: r.c = 2'b00;
         TMDS_CTRL_01: r.c = 2'b01;
         TMDS_CTRL_10: r.c = 2'b10;
         TMDS_CTRL_11: r.c = 2'b11;
         default: begin
            // bit 8 selects whether the encoder chained with XOR or XNOR
            r.de      = 1'b1;
            r.data[0] = q[0];
            for (int i = 1; i < 8; i++) begin
               r.data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
            end
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Word-alignment search: counts control tokens per observation window and
// requests deserializer bitslips until enough tokens are seen to declare lock.
module tmds_align_fsm
   import tmds_pkg::*;
#(
   parameter int C_window_bits = 12,
   parameter int C_ctrl_min    = 64,
   parameter int C_slip_wait   = 16
) (
   input  logic       clk_pixel,
   input  logic       rst,
   input  logic       ctrl_tok,
   output logic       locked,
   output logic       bitslip,
   output logic [3:0] slip_count
);

   localparam int CNT_W = $clog2(C_ctrl_min + 1);
   localparam int SET_W = $clog2(C_slip_wait + 1);

   align_state_t             state_q, state_d;
   logic [C_window_bits-1:0] win_q, win_d;
   logic [CNT_W-1:0]         ctrl_q, ctrl_d, ctrl_sum;
   logic [SET_W-1:0]         settle_q, settle_d;
   logic [3:0]               slip_q, slip_d;
   logic                     win_wrap;
   logic                     reach;

   always_comb begin
      win_wrap = &win_q;
      // ctrl_sum includes this cycle's token so a token on the wrap cycle still counts
      ctrl_sum = (ctrl_tok && (ctrl_q != CNT_W'(C_ctrl_min))) ? ctrl_q + CNT_W'(1) : ctrl_q;
      reach    = (ctrl_sum == CNT_W'(C_ctrl_min));

      win_d    = win_q + C_window_bits'(1);
      ctrl_d   = win_wrap ? '0 : ctrl_sum;
      settle_d = settle_q;
      slip_d   = slip_q;
      state_d  = state_q;

      case (state_q)
         ST_SEARCH: begin
            if (reach) begin
               state_d = ST_LOCKED;
            end else if (win_wrap) begin
               state_d = ST_SLIP;
            end
         end
         ST_SLIP: begin
            slip_d   = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
            settle_d = '0;
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == SET_W'(C_slip_wait - 1)) begin
               state_d = ST_SEARCH;
               win_d   = '0;
               ctrl_d  = '0;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         ST_LOCKED: begin
            if (win_wrap && (ctrl_sum == '0)) begin
               state_d = ST_SEARCH;
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         state_q  <= ST_SEARCH;
         win_q    <= '0;
         ctrl_q   <= '0;
         settle_q <= '0;
         slip_q   <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         ctrl_q   <= ctrl_d;
         settle_q <= settle_d;
         slip_q   <= slip_d;
      end
   end

   assign locked     = (state_q == ST_LOCKED);
   assign bitslip    = (state_q == ST_SLIP);
   assign slip_count = slip_q;

endmodule

// File: rtl/tmds_decoder_align.sv
// One TMDS receive channel: two-stage symbol decode pipeline plus the
// word-alignment controller driving the deserializer bitslip.
module tmds_decoder_align
   import tmds_pkg::*;
#(
   parameter int C_window_bits = 12,
   parameter int C_ctrl_min    = 64,
   parameter int C_slip_wait   = 16
) (
   input  logic       clk_pixel,
   input  logic       rst,
   input  logic [9:0] in_symbol,
   output logic [7:0] out_data,
   output logic [1:0] out_c,
   output logic       out_de,
   output logic       out_locked,
   output logic       out_bitslip,
   output logic [3:0] out_slip_count
);

   logic [9:0] sym_p1_q, sym_p1_d;
   logic       vld_p1_q, vld_p1_d;
   logic [7:0] data_p2_q, data_p2_d;
   logic [1:0] c_p2_q, c_p2_d;
   logic       de_p2_q, de_p2_d;
   tmds_dec_t  dec_p1;
   logic       ctrl_tok_p1;

   always_comb begin
      sym_p1_d  = in_symbol;
      vld_p1_d  = 1'b1;

      // stage 1 -> stage 2: decode the registered symbol
      dec_p1    = tmds_decode(sym_p1_q);
      data_p2_d = data_p2_q;
      c_p2_d    = c_p2_q;
      de_p2_d   = de_p2_q;
      if (vld_p1_q) begin
         data_p2_d = dec_p1.data;
         de_p2_d   = dec_p1.de;
         if (!dec_p1.de) begin
            c_p2_d = dec_p1.c;
         end
      end
      ctrl_tok_p1 = vld_p1_q && !dec_p1.de;
   end

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         sym_p1_q  <= '0;
         vld_p1_q  <= 1'b0;
         data_p2_q <= '0;
         c_p2_q    <= '0;
         de_p2_q   <= 1'b0;
      end else begin
         sym_p1_q  <= sym_p1_d;
         vld_p1_q  <= vld_p1_d;
         data_p2_q <= data_p2_d;
         c_p2_q    <= c_p2_d;
         de_p2_q   <= de_p2_d;
      end
   end

   tmds_align_fsm #(
      .C_window_bits (C_window_bits),
      .C_ctrl_min    (C_ctrl_min),
      .C_slip_wait   (C_slip_wait)
   ) u_align (
      .clk_pixel  (clk_pixel),
      .rst        (rst),
      .ctrl_tok   (ctrl_tok_p1),
      .locked     (out_locked),
      .bitslip    (out_bitslip),
      .slip_count (out_slip_count)
   );

   assign out_data = data_p2_q;
   assign out_c    = c_p2_q;
   assign out_de   = de_p2_q;

endmodule

// File: tb/tb_tmds_decoder_align.sv
// Directed bench for tmds_decoder_align: token/data decode, bitslip search with a
// rotating deserializer model, lock loss/recovery, async reset and window edges.
module tb_tmds_decoder_align;

   logic       clk_pixel = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] in_symbol = '0;
   logic [7:0] out_data;
   logic [1:0] out_c;
   logic       out_de;
   logic       out_locked;
   logic       out_bitslip;
   logic [3:0] out_slip_count;

   tmds_decoder_align dut (
      .clk_pixel      (clk_pixel),
      .rst            (rst),
      .in_symbol      (in_symbol),
      .out_data       (out_data),
      .out_c          (out_c),
      .out_de         (out_de),
      .out_locked     (out_locked),
      .out_bitslip    (out_bitslip),
      .out_slip_count (out_slip_count)
   );

   always #5 clk_pixel = ~clk_pixel;

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_slips = 0;
   int         cyc = 0;
   int         last_slip = 0;
   int         off = 0;
   int         pos = 0;
   logic [9:0] line_mem [0:1343];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference DVI encoder with running disparity
   task automatic tmds_encode(input logic [7:0] d, inout int disp, output logic [9:0] sym);
      logic [8:0] qm;
      int n1d, n1q, n0q;
      n1d   = $countones(d);
      qm[0] = d[0];
      if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
         qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (disp == 0 || n1q == n0q) begin
         sym  = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         disp = qm[8] ? disp + n1q - n0q : disp + n0q - n1q;
      end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
         sym  = {1'b1, qm[8], ~qm[7:0]};
         disp = disp + (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
         sym  = {1'b0, qm[8], qm[7:0]};
         disp = disp - (qm[8] ? 0 : 2) + n1q - n0q;
      end
   endtask

   // deserializer word starting 'o' bits into symbol p of the cyclic line stream
   function automatic logic [9:0] rx_word(input int p, input int o);
      logic [9:0] w;
      logic [9:0] s;
      int n;
      for (int k = 0; k < 10; k++) begin
         n    = 10 * p + o + k;
         s    = line_mem[(n / 10) % 1344];
         w[k] = s[n % 10];
      end
      return w;
   endfunction

   task automatic step(input logic [9:0] sym);
      in_symbol = sym;
      @(posedge clk_pixel);
      #1;
      cyc++;
      if (out_bitslip) begin
         if (n_slips > 0) check("slip_gap_ge17", 32'(cyc - last_slip >= 17), 32'd1);
         n_slips++;
         last_slip = cyc;
         off++;
      end
   endtask

   task automatic line_step();
      step(rx_word(pos, off));
      pos = (pos + 1) % 1344;
   endtask

   task automatic do_reset();
      @(negedge clk_pixel);
      rst = 1'b1;
      @(negedge clk_pixel);
      rst = 1'b0;
      n_slips = 0;
      cyc = 0;
   endtask

   initial begin
      logic [9:0] toks [0:3];
      logic [9:0] sym;
      int disp;
      int n;
      int slips_before;
      logic locked_seen;

      toks[0] = 10'h354;
      toks[1] = 10'h0AB;
      toks[2] = 10'h154;
      toks[3] = 10'h2AB;
      for (int p = 0; p < 1344; p++) line_mem[p] = (p < 1024) ? 10'h000 : 10'h354;

      // reset state
      @(negedge clk_pixel);
      @(negedge clk_pixel);
      check("rst_data", 32'(out_data), 32'h0);
      check("rst_c", 32'(out_c), 32'h0);
      check("rst_de", 32'(out_de), 32'h0);
      check("rst_locked", 32'(out_locked), 32'h0);
      check("rst_bitslip", 32'(out_bitslip), 32'h0);
      check("rst_slip_count", 32'(out_slip_count), 32'h0);
      rst = 1'b0;

      // control tokens, two-cycle latency
      for (int j = 0; j <= 4; j++) begin
         step((j < 4) ? toks[j] : 10'h2AB);
         if (j >= 1) check("ctrl_token", 32'({out_de, out_c, out_data}), 32'({1'b0, 2'(j - 1), 8'h00}));
      end

      // all 256 bytes through the reference encoder; out_c holds 11
      disp = 0;
      for (int j = 0; j <= 256; j++) begin
         tmds_encode(8'(j % 256), disp, sym);
         step(sym);
         if (j >= 1) check("data_byte", 32'({out_de, out_c, out_data}), 32'({1'b1, 2'b11, 8'(j - 1)}));
      end

      // line stream rotated by 3 bits: 7 slips then lock
      do_reset();
      off = 3;
      pos = 0;
      n = 0;
      while (!out_locked && n < 35000) begin
         line_step();
         n++;
      end
      check("line_locked", 32'(out_locked), 32'd1);
      check("line_slip_pulses", 32'(n_slips), 32'd7);
      check("line_slip_count", 32'(out_slip_count), 32'd7);

      // data-only stream drops lock at a window wrap
      n = 0;
      while (out_locked && n < 9000) begin
         step(10'h000);
         n++;
      end
      check("lock_dropped", 32'(out_locked), 32'd0);
      check("drop_at_window", 32'(n >= 4096 && n <= 8193), 32'd1);
      check("drop_no_slip", 32'(out_bitslip), 32'd0);
      slips_before = n_slips;
      n = 0;
      while (!out_locked && n < 5000) begin
         line_step();
         n++;
      end
      check("relocked", 32'(out_locked), 32'd1);
      check("relock_no_slips", 32'(n_slips), 32'(slips_before));
      check("relock_slip_count", 32'(out_slip_count), 32'd7);

      // lock at slip_count 5, then async reset mid-cycle
      do_reset();
      off = 5;
      pos = 0;
      n = 0;
      while (!out_locked && n < 25000) begin
         line_step();
         n++;
      end
      check("lock5_locked", 32'(out_locked), 32'd1);
      check("lock5_slip_count", 32'(out_slip_count), 32'd5);
      n = 0;
      while (!out_de && n < 2000) begin
         line_step();
         n++;
      end
      check("lock5_data_seen", 32'(out_de), 32'd1);
      @(posedge clk_pixel);
      #2 rst = 1'b1;
      #1;
      check("async_rst_outputs",
            32'({out_locked, out_bitslip, out_slip_count, out_de, out_c, out_data}), 32'h0);
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      rst = 1'b0;
      n_slips = 0;
      cyc = 0;
      check("post_rst_slip_count", 32'(out_slip_count), 32'd0);
      check("post_rst_locked", 32'(out_locked), 32'd0);

      // 63 tokens per window: never locks, one slip per window
      locked_seen = 1'b0;
      for (int j = 0; j <= 8220; j++) begin
         step(((j % 4113) >= 100 && (j % 4113) <= 162) ? 10'h354 : 10'h000);
         if (out_locked) locked_seen = 1'b1;
      end
      check("c63_never_locked", 32'(locked_seen), 32'd0);
      check("c63_slip_pulses", 32'(n_slips), 32'd2);
      check("c63_slip_count", 32'(out_slip_count), 32'd2);

      // 64th token lands on the window-wrap cycle: lock wins over slip
      do_reset();
      for (int j = 0; j <= 4100; j++) begin
         step((j >= 4031 && j <= 4094) ? 10'h354 : 10'h000);
         if (j == 4094) check("c64_before_wrap", 32'(out_locked), 32'd0);
         if (j == 4095) check("c64_lock_on_wrap", 32'(out_locked), 32'd1);
      end
      check("c64_no_slips", 32'(n_slips), 32'd0);
      check("c64_slip_count", 32'(out_slip_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
